// File: rtl/proc_sched_if.sv
// Handshake bundle between the packet scheduler and its neighbours:
// ingress address queue, proc start/ready pair and completion report.
interface proc_sched_if #(
   parameter int ADDR_W = 32
);
   // ingress packet addresses
   logic              enq_valid;
   logic [ADDR_W-1:0] enq_addr;
   logic              enq_ready;
   // proc pipeline start/ready
   logic              proc_start;
   logic [ADDR_W-1:0] proc_addr;
   logic              proc_ready;
   // completion / timeout report
   logic              done_valid;
   logic [ADDR_W-1:0] done_addr;
   logic              done_err;
   logic              done_ready;

   // scheduler side
   modport master (
      input  enq_valid, enq_addr,
      output enq_ready,
      output proc_start, proc_addr,
      input  proc_ready,
      output done_valid, done_addr, done_err,
      input  done_ready
   );

   // environment side (producer, proc pipeline, report consumer)
   modport slave (
      output enq_valid, enq_addr,
      input  enq_ready,
      input  proc_start, proc_addr,
      output proc_ready,
      input  done_valid, done_addr, done_err,
      output done_ready
   );
endinterface

// File: rtl/proc_sched.sv
// Packet dispatch controller: queues packet addresses, runs proc on one packet
// at a time with a watchdog, reports completions/timeouts and grants
// reconfiguration windows only while proc is idle.
module proc_sched #(
   parameter int ADDR_W  = 32,
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                         clk,
   input  logic                         rst,        // asynchronous, active-low
   proc_sched_if.master                 bus,
   input  logic                         cfg_req_i,
   output logic                         cfg_grant_o,
   output logic                         fault_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      RUN    = 3'd2,
      REPORT = 3'd3,
      CFG    = 3'd4,
      FAULT  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [WW-1:0]     wd_q, wd_d;
   logic              proc_start_q, proc_start_d;
   logic [ADDR_W-1:0] proc_addr_q, proc_addr_d;
   logic              done_valid_q, done_valid_d;
   logic [ADDR_W-1:0] done_addr_q, done_addr_d;
   logic              done_err_q, done_err_d;
   logic              cfg_grant_q, cfg_grant_d;
   logic              fault_q, fault_d;
   logic              push, pop;

   logic [ADDR_W-1:0] mem [DEPTH];

   // pointers wrap modulo DEPTH, which need not be a power of two
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // next-state, FIFO bookkeeping and registered-output computation
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      wd_d         = wd_q;
      proc_start_d = proc_start_q;
      proc_addr_d  = proc_addr_q;
      done_valid_d = done_valid_q;
      done_addr_d  = done_addr_q;
      done_err_d   = done_err_q;
      cfg_grant_d  = cfg_grant_q;
      fault_d      = fault_q;
      // ready comes from the registered count, so a full FIFO refuses a push
      // even in the cycle that pops
      push         = bus.enq_valid && (count_q < DEPTH_C);
      pop          = 1'b0;

      case (state_q)
         IDLE: begin
            // configuration takes precedence over dispatch
            if (cfg_req_i) begin
               cfg_grant_d = 1'b1;
               state_d     = CFG;
            end else if ((count_q != '0) && !fault_q) begin
               pop          = 1'b1;
               proc_addr_d  = mem[rd_ptr_q];
               proc_start_d = 1'b1;
               state_d      = START;
            end
         end
         START: begin
            // proc still shows the previous packet's ready; ignore it here
            wd_d    = '0;
            state_d = RUN;
         end
         RUN: begin
            if (bus.proc_ready) begin
               proc_start_d = 1'b0;
               done_valid_d = 1'b1;
               done_addr_d  = proc_addr_q;
               done_err_d   = 1'b0;
               state_d      = REPORT;
            end else if (wd_q == WD_LAST) begin
               proc_start_d = 1'b0;
               done_valid_d = 1'b1;
               done_addr_d  = proc_addr_q;
               done_err_d   = 1'b1;
               fault_d      = 1'b1;
               state_d      = REPORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         REPORT: begin
            if (bus.done_ready) begin
               done_valid_d = 1'b0;
               state_d      = fault_q ? FAULT : IDLE;
            end
         end
         CFG: begin
            if (!cfg_req_i) begin
               cfg_grant_d = 1'b0;
               state_d     = fault_q ? FAULT : IDLE;
            end
         end
         FAULT: begin
            if (cfg_req_i) begin
               cfg_grant_d = 1'b1;
               state_d     = CFG;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FSM and control registers; reset aborts any packet in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         wd_q         <= '0;
         proc_start_q <= 1'b0;
         proc_addr_q  <= '0;
         done_valid_q <= 1'b0;
         done_addr_q  <= '0;
         done_err_q   <= 1'b0;
         cfg_grant_q  <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         wd_q         <= wd_d;
         proc_start_q <= proc_start_d;
         proc_addr_q  <= proc_addr_d;
         done_valid_q <= done_valid_d;
         done_addr_q  <= done_addr_d;
         done_err_q   <= done_err_d;
         cfg_grant_q  <= cfg_grant_d;
         fault_q      <= fault_d;
      end
   end

   // address storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.enq_addr;
   end

   assign bus.enq_ready  = (count_q < DEPTH_C);
   assign bus.proc_start = proc_start_q;
   assign bus.proc_addr  = proc_addr_q;
   assign bus.done_valid = done_valid_q;
   assign bus.done_addr  = done_addr_q;
   assign bus.done_err   = done_err_q;
   assign cfg_grant_o    = cfg_grant_q;
   assign fault_o        = fault_q;
   assign count_o        = count_q;

endmodule

// File: tb/tb_proc_sched.sv
// Directed bench for proc_sched: cycle-by-cycle vector table for dispatch,
// ordering and config arbitration, plus sequences for full FIFO, watchdog
// timeout, asynchronous reset mid-packet and report hold.
module tb_proc_sched;

   localparam int AW      = 32;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 32;
   localparam int CW      = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_req = 1'b0;
   logic          cfg_grant;
   logic          fault;
   logic [CW-1:0] count;

   int n_vec = 0;
   int n_mis = 0;

   proc_sched_if #(.ADDR_W(AW)) bus ();

   proc_sched #(.ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .cfg_req_i   (cfg_req),
      .cfg_grant_o (cfg_grant),
      .fault_o     (fault),
      .count_o     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ev; int ea; bit pr; bit dr; bit cr;      // inputs
      bit ps; int pa; bit dv; int da; bit cg; int cnt; // expected outputs
   } vec_t;

   function automatic vec_t mk(bit ev, int ea, bit pr, bit dr, bit cr,
                               bit ps, int pa, bit dv, int da, bit cg, int cnt);
      vec_t v;
      v.ev = ev; v.ea = ea; v.pr = pr; v.dr = dr; v.cr = cr;
      v.ps = ps; v.pa = pa; v.dv = dv; v.da = da; v.cg = cg; v.cnt = cnt;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // full output comparison
   task automatic check_all(string name, bit er, bit ps, int pa, bit dv, int da,
                            bit de, bit cg, bit f, int cnt);
      n_vec++;
      if (bus.enq_ready !== er || bus.proc_start !== ps || bus.proc_addr !== pa ||
          bus.done_valid !== dv || bus.done_addr !== da || bus.done_err !== de ||
          cfg_grant !== cg || fault !== f || int'(count) !== cnt) begin
         n_mis++;
         $display("FAIL %s: got er=%b ps=%b pa=%h dv=%b da=%h de=%b cg=%b f=%b cnt=%0d, want er=%b ps=%b pa=%h dv=%b da=%h de=%b cg=%b f=%b cnt=%0d",
                  name, bus.enq_ready, bus.proc_start, bus.proc_addr, bus.done_valid,
                  bus.done_addr, bus.done_err, cfg_grant, fault, count,
                  er, ps, pa[AW-1:0], dv, da[AW-1:0], de, cg, f, cnt);
      end else begin
         $display("ok   %s", name);
      end
   endtask

   task automatic check1(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // wait for dispatch, complete it via proc_ready, accept the report
   task automatic run_packet(string name, logic [31:0] exp_addr);
      int n = 0;
      while (bus.proc_start !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (bus.proc_start !== 1'b1) begin
         n_vec++;
         n_mis++;
         $display("FAIL %s: no proc_start within 20 cycles, want start", name);
         return;
      end
      check1({name, "_start_addr"}, bus.proc_addr, exp_addr);
      step();                         // leave the blanking cycle
      bus.proc_ready = 1'b1;
      step();
      bus.proc_ready = 1'b0;
      check1({name, "_done_valid"}, 32'(bus.done_valid), 32'd1);
      check1({name, "_done_addr"}, bus.done_addr, exp_addr);
      check1({name, "_done_err"}, 32'(bus.done_err), 32'd0);
      bus.done_ready = 1'b1;
      step();
      bus.done_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want $finish");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t vecs[$];

      bus.enq_valid  = 1'b0;
      bus.enq_addr   = '0;
      bus.proc_ready = 1'b0;
      bus.done_ready = 1'b0;

      //                 ev  ea     pr dr cr   ps pa     dv da     cg cnt
      // single packet, START ignores stale ready, completion after 5 RUN cycles
      vecs.push_back(mk(1, 'h40, 0, 0, 0,   0, 'h00, 0, 'h00, 0, 1));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    1, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h40, 0, 'h00, 0, 0));
      vecs.push_back(mk(0, 0,    1, 0, 0,   0, 'h40, 1, 'h40, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   0, 'h40, 1, 'h40, 0, 0));
      vecs.push_back(mk(0, 0,    0, 1, 0,   0, 'h40, 0, 'h40, 0, 0));
      // back-to-back pushes, in-order dispatch, two idle start cycles between
      vecs.push_back(mk(1, 'h10, 0, 0, 0,   0, 'h40, 0, 'h40, 0, 1));
      vecs.push_back(mk(1, 'h20, 0, 0, 0,   1, 'h10, 0, 'h40, 0, 1));
      vecs.push_back(mk(1, 'h30, 0, 0, 0,   1, 'h10, 0, 'h40, 0, 2));
      vecs.push_back(mk(0, 0,    1, 0, 0,   0, 'h10, 1, 'h10, 0, 2));
      vecs.push_back(mk(0, 0,    0, 1, 0,   0, 'h10, 0, 'h10, 0, 2));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h20, 0, 'h10, 0, 1));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h20, 0, 'h10, 0, 1));
      vecs.push_back(mk(0, 0,    1, 0, 0,   0, 'h20, 1, 'h20, 0, 1));
      vecs.push_back(mk(0, 0,    0, 1, 0,   0, 'h20, 0, 'h20, 0, 1));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h30, 0, 'h20, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h30, 0, 'h20, 0, 0));
      vecs.push_back(mk(0, 0,    1, 0, 0,   0, 'h30, 1, 'h30, 0, 0));
      // cfg request in REPORT waits for IDLE
      vecs.push_back(mk(0, 0,    0, 1, 1,   0, 'h30, 0, 'h30, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 1,   0, 'h30, 0, 'h30, 1, 0));
      vecs.push_back(mk(0, 0,    0, 0, 1,   0, 'h30, 0, 'h30, 1, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   0, 'h30, 0, 'h30, 0, 0));
      // cfg beats dispatch with a non-empty FIFO
      vecs.push_back(mk(1, 'h55, 0, 0, 0,   0, 'h30, 0, 'h30, 0, 1));
      vecs.push_back(mk(0, 0,    0, 0, 1,   0, 'h30, 0, 'h30, 1, 1));
      vecs.push_back(mk(0, 0,    0, 0, 0,   0, 'h30, 0, 'h30, 0, 1));
      vecs.push_back(mk(0, 0,    0, 0, 0,   1, 'h55, 0, 'h30, 0, 0));
      // cfg request during START/RUN/REPORT is held off until IDLE
      vecs.push_back(mk(0, 0,    0, 0, 1,   1, 'h55, 0, 'h30, 0, 0));
      vecs.push_back(mk(0, 0,    1, 0, 1,   0, 'h55, 1, 'h55, 0, 0));
      vecs.push_back(mk(0, 0,    0, 1, 1,   0, 'h55, 0, 'h55, 0, 0));
      vecs.push_back(mk(0, 0,    0, 0, 1,   0, 'h55, 0, 'h55, 1, 0));
      vecs.push_back(mk(0, 0,    0, 0, 0,   0, 'h55, 0, 'h55, 0, 0));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      foreach (vecs[i]) begin
         bus.enq_valid  = vecs[i].ev;
         bus.enq_addr   = vecs[i].ea;
         bus.proc_ready = vecs[i].pr;
         bus.done_ready = vecs[i].dr;
         cfg_req        = vecs[i].cr;
         step();
         check_all($sformatf("vec%0d", i), 1, vecs[i].ps, vecs[i].pa, vecs[i].dv,
                   vecs[i].da, 0, vecs[i].cg, 0, vecs[i].cnt);
      end
      bus.enq_valid  = 1'b0;
      bus.proc_ready = 1'b0;
      bus.done_ready = 1'b0;
      cfg_req        = 1'b0;

      // full FIFO while proc is busy: DEPTH+1 offered, only DEPTH queued
      begin
         int exp_cnt[6] = '{1, 1, 2, 3, 4, 4};
         int exp_rdy[6] = '{1, 1, 1, 1, 0, 0};
         for (int k = 0; k < 6; k++) begin
            bus.enq_valid = 1'b1;
            bus.enq_addr  = 32'hA0 + k;
            step();
            check1($sformatf("full_cnt%0d", k), 32'(count), exp_cnt[k]);
            check1($sformatf("full_rdy%0d", k), 32'(bus.enq_ready), exp_rdy[k]);
         end
         bus.enq_valid = 1'b0;
         for (int k = 0; k < 5; k++)
            run_packet($sformatf("drain%0d", k), 32'hA0 + k);
         repeat (4) step();
         check1("drain_no_extra_start", 32'(bus.proc_start), 32'd0);
         check1("drain_cnt", 32'(count), 32'd0);
      end

      // watchdog: proc never answers
      bus.enq_valid = 1'b1;
      bus.enq_addr  = 32'hE0;
      step();
      bus.enq_valid = 1'b0;
      step();
      check1("to_start", 32'(bus.proc_start), 32'd1);
      check1("to_addr", bus.proc_addr, 32'hE0);
      step();                                   // now RUN, watchdog 0
      repeat (TIMEOUT - 1) step();
      check1("to_not_early_dv", 32'(bus.done_valid), 32'd0);
      check1("to_not_early_ps", 32'(bus.proc_start), 32'd1);
      step();
      check1("to_dv", 32'(bus.done_valid), 32'd1);
      check1("to_err", 32'(bus.done_err), 32'd1);
      check1("to_fault", 32'(fault), 32'd1);
      check1("to_ps_low", 32'(bus.proc_start), 32'd0);
      bus.done_ready = 1'b1;
      step();
      bus.done_ready = 1'b0;
      check1("to_dv_clr", 32'(bus.done_valid), 32'd0);
      bus.enq_valid = 1'b1;
      bus.enq_addr  = 32'hE1;
      step();
      bus.enq_valid = 1'b0;
      repeat (5) step();
      check1("fault_no_dispatch", 32'(bus.proc_start), 32'd0);
      check1("fault_fifo_accepts", 32'(count), 32'd1);
      cfg_req = 1'b1;
      step();
      check1("fault_cfg_grant", 32'(cfg_grant), 32'd1);
      cfg_req = 1'b0;
      step();
      check1("fault_cfg_release", 32'(cfg_grant), 32'd0);
      step();
      check1("fault_sticky", 32'(fault), 32'd1);
      check1("fault_still_no_start", 32'(bus.proc_start), 32'd0);

      // asynchronous reset in the middle of a packet
      rst = 1'b0;
      #1;
      check1("rst_clears_fault", 32'(fault), 32'd0);
      step();
      rst = 1'b1;
      bus.enq_valid = 1'b1;
      bus.enq_addr  = 32'h60;
      step();
      bus.enq_addr  = 32'h61;
      step();
      bus.enq_valid = 1'b0;
      step();                                   // RUN on 0x60, 0x61 queued
      check1("mid_run_ps", 32'(bus.proc_start), 32'd1);
      #3;
      rst = 1'b0;
      #1;
      check_all("reset_mid_run", 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      rst = 1'b1;
      repeat (4) step();
      check1("post_rst_no_start", 32'(bus.proc_start), 32'd0);
      check1("post_rst_no_report", 32'(bus.done_valid), 32'd0);

      // report held stable while the consumer stalls
      bus.enq_valid = 1'b1;
      bus.enq_addr  = 32'h70;
      step();
      bus.enq_valid = 1'b0;
      step();                                   // START
      step();                                   // RUN
      bus.proc_ready = 1'b1;
      step();
      bus.proc_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check1($sformatf("hold_dv%0d", k), 32'(bus.done_valid), 32'd1);
         check1($sformatf("hold_da%0d", k), bus.done_addr, 32'h70);
         step();
      end
      bus.done_ready = 1'b1;
      step();
      bus.done_ready = 1'b0;
      check1("hold_release", 32'(bus.done_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
